// File: rtl/perf_mon_pkg.sv
// Shared constants for the pipeline event monitor: default event bit positions
// and the trace-record width helper.
package perf_mon_pkg;

    localparam int unsigned EVT_STALLF = 0;
    localparam int unsigned EVT_STALLD = 1;
    localparam int unsigned EVT_FLUSHD = 2;
    localparam int unsigned EVT_FLUSHE = 3;
    localparam int unsigned EVT_BRANCH = 4;

    localparam int unsigned NUM_EVT_DEFAULT = 5;

    // A record is {timestamp, masked event vector}.
    function automatic int unsigned trace_rec_w(input int unsigned ts_w,
                                                input int unsigned num_evt);
        return ts_w + num_evt;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers for full/empty detection
// and a registered occupancy level.
module trace_fifo #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign do_pop  = pop_i & ~empty & ~clr_i;
    assign do_push = push_i & (~full | do_pop) & ~clr_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    assign valid_o = ~empty;
    assign data_o  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign full_o  = full;
    assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/pipeline_event_monitor.sv
// Per-event and cycle counters for the pipelined core, plus a time-stamped
// trace FIFO of masked event vectors drained over valid/ready.
module pipeline_event_monitor
    import perf_mon_pkg::*;
#(
    parameter int unsigned NUM_EVT  = 5,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SATURATE = 1,
    parameter int unsigned TS_W     = 16,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic                                 clr,
    input  logic [NUM_EVT-1:0]                   evt_i,
    input  logic [NUM_EVT-1:0]                   evt_mask_i,
    input  logic [$clog2(NUM_EVT+1)-1:0]         sel_i,
    output logic [CNT_W-1:0]                     cnt_o,
    output logic                                 trace_valid_o,
    input  logic                                 trace_ready_i,
    output logic [trace_rec_w(TS_W, NUM_EVT)-1:0] trace_data_o,
    output logic [$clog2(DEPTH):0]               trace_level_o,
    output logic                                 overflow_o
);

    localparam int unsigned REC_W = trace_rec_w(TS_W, NUM_EVT);

    logic [NUM_EVT:0][CNT_W-1:0] cnt_all;
    logic [NUM_EVT:0]            inc_en;
    logic [NUM_EVT-1:0]          evt_masked;
    logic                        capture;
    logic                        pop;
    logic                        fifo_full;
    logic [REC_W-1:0]            rec;
    logic [CNT_W-1:0]            cnt_o_q, cnt_o_d;
    logic                        overflow_q, overflow_d;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        if ((SATURATE != 0) && (&v)) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Top bit is the cycle counter, which advances on every enabled cycle.
    assign inc_en = en ? {1'b1, evt_i} : '0;

    for (genvar i = 0; i < NUM_EVT + 1; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
                cnt_d = '0;
            end else if (inc_en[i]) begin
                cnt_d = cnt_inc(cnt_q);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_all[i] = cnt_q;
    end

    always_comb begin
        cnt_o_d = '0;
        if (32'(sel_i) <= NUM_EVT) begin
            cnt_o_d = cnt_all[sel_i];
        end
    end

    assign evt_masked = evt_i & evt_mask_i;
    assign capture    = en & (|evt_masked) & ~clr;
    assign pop        = trace_valid_o & trace_ready_i;
    // Timestamp is the cycle count before this cycle's increment.
    assign rec        = {cnt_all[NUM_EVT][TS_W-1:0], evt_masked};

    always_comb begin
        overflow_d = overflow_q;
        if (clr) begin
            overflow_d = 1'b0;
        end else if (capture && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_o_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_o_q    <= cnt_o_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (clr),
        .push_i  (capture),
        .data_i  (rec),
        .pop_i   (pop),
        .valid_o (trace_valid_o),
        .data_o  (trace_data_o),
        .full_o  (fifo_full),
        .level_o (trace_level_o)
    );

    assign cnt_o      = cnt_o_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pipeline_event_monitor.sv
// Randomised and directed bench for pipeline_event_monitor, checked every cycle
// against a queue/arithmetic model of the counters and trace FIFO.
module tb_pipeline_event_monitor;

    localparam int DEP = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        en    = 1'b0;
    logic        clr   = 1'b0;
    logic        ready = 1'b0;
    logic [4:0]  evt   = '0;
    logic [4:0]  mask  = '0;
    logic [2:0]  sel   = '0;

    logic [31:0] cnt_o;
    logic        valid;
    logic [20:0] data;
    logic [3:0]  level;
    logic        ovf;

    logic [3:0]  cnt_s, cnt_w;
    logic        valid_s, valid_w, ovf_s, ovf_w;
    logic [8:0]  data_s, data_w;
    logic [3:0]  level_s, level_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_event_monitor u_dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .clr           (clr),
        .evt_i         (evt),
        .evt_mask_i    (mask),
        .sel_i         (sel),
        .cnt_o         (cnt_o),
        .trace_valid_o (valid),
        .trace_ready_i (ready),
        .trace_data_o  (data),
        .trace_level_o (level),
        .overflow_o    (ovf)
    );

    pipeline_event_monitor #(.CNT_W(4), .SATURATE(1), .TS_W(4)) u_sat4 (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .clr           (clr),
        .evt_i         (evt),
        .evt_mask_i    (mask),
        .sel_i         (sel),
        .cnt_o         (cnt_s),
        .trace_valid_o (valid_s),
        .trace_ready_i (ready),
        .trace_data_o  (data_s),
        .trace_level_o (level_s),
        .overflow_o    (ovf_s)
    );

    pipeline_event_monitor #(.CNT_W(4), .SATURATE(0), .TS_W(4)) u_wrap4 (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .clr           (clr),
        .evt_i         (evt),
        .evt_mask_i    (mask),
        .sel_i         (sel),
        .cnt_o         (cnt_w),
        .trace_valid_o (valid_w),
        .trace_ready_i (ready),
        .trace_data_o  (data_w),
        .trace_level_o (level_w),
        .overflow_o    (ovf_w)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value of an unbounded count as seen in a w-bit saturating or wrapping counter.
    function automatic logic [31:0] fit(input longint v, input int w, input bit sat);
        longint top;
        top = (longint'(1) << w) - 1;
        if (sat && v > top) return 32'(top);
        return 32'(v % (top + 1));
    endfunction

    // Model: true counts since the last clear, expected registered cnt_o, record queue.
    longint      cnt_m [6];
    logic [31:0] exp_cnt;
    logic [3:0]  exp_s, exp_w;
    logic [20:0] q [$];
    bit          ovf_m;

    always @(posedge clk or negedge reset) begin : model
        logic [4:0] m;
        bit         popm, capm;
        if (!reset) begin
            foreach (cnt_m[i]) cnt_m[i] = 0;
            exp_cnt = '0;
            exp_s   = '0;
            exp_w   = '0;
            q.delete();
            ovf_m   = 1'b0;
        end else begin
            if (sel <= 3'd5) begin
                exp_cnt = fit(cnt_m[sel], 32, 1'b1);
                exp_s   = 4'(fit(cnt_m[sel], 4, 1'b1));
                exp_w   = 4'(fit(cnt_m[sel], 4, 1'b0));
            end else begin
                exp_cnt = '0;
                exp_s   = '0;
                exp_w   = '0;
            end
            m    = evt & mask;
            popm = (q.size() != 0) && ready && !clr;
            capm = en && (m != 0) && !clr;
            if (clr) begin
                q.delete();
                ovf_m = 1'b0;
                foreach (cnt_m[i]) cnt_m[i] = 0;
            end else begin
                if (popm) void'(q.pop_front());
                if (capm) begin
                    if (q.size() < DEP) q.push_back({16'(cnt_m[5]), m});
                    else ovf_m = 1'b1;
                end
                if (en) begin
                    cnt_m[5]++;
                    for (int i = 0; i < 5; i++) if (evt[i]) cnt_m[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cnt_o", cnt_o, exp_cnt);
        chk("cnt_o_sat4", cnt_s, exp_s);
        chk("cnt_o_wrap4", cnt_w, exp_w);
        chk("trace_valid", valid, q.size() != 0);
        chk("trace_level", level, q.size());
        if (q.size() != 0) chk("trace_data", data, q[0]);
        chk("overflow", ovf, ovf_m);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        tick(1);
        chk("lit_reset_cnt", cnt_o, 0);
        chk("lit_reset_valid", valid, 0);
        chk("lit_reset_level", level, 0);
        chk("lit_reset_ovf", ovf, 0);
        chk("lit_reset_data", data, 0);
        reset = 1'b1;

        // Basic counting
        en = 1; evt = 5'b00001; sel = 0; mask = 0;
        tick(3);
        en = 0; evt = 0;
        tick(2);
        chk("lit_basic_evt0", cnt_o, 3);
        sel = 5;
        tick(2);
        chk("lit_basic_cycles", cnt_o, 3);

        // Saturate / wrap on 4-bit instances
        clr = 1; tick(1); clr = 0;
        sel = 1; en = 1; evt = 5'b00010;
        tick(20);
        en = 0; evt = 0;
        tick(2);
        chk("lit_sat_main", cnt_o, 20);
        chk("lit_sat4", cnt_s, 15);
        chk("lit_wrap4", cnt_w, 4);

        // Capture and masking at cycle counter 7
        clr = 1; tick(1); clr = 0;
        en = 1; evt = 0; mask = 5'b10100;
        tick(7);
        evt = 5'b10110;
        tick(1);
        en = 0; evt = 0;
        chk("lit_cap_valid", valid, 1);
        chk("lit_cap_level", level, 1);
        chk("lit_cap_data", data, 21'h0000F4);
        ready = 1; tick(1); ready = 0;
        chk("lit_cap_drained", valid, 0);

        // Overflow with 9 events into 8 entries
        clr = 1; tick(1); clr = 0;
        mask = 5'h1f; en = 1; evt = 5'b00001;
        tick(9);
        en = 0; evt = 0;
        chk("lit_ovf_level", level, 8);
        chk("lit_ovf_flag", ovf, 1);
        ready = 1;
        for (int k = 0; k < 8; k++) begin
            chk("lit_ovf_order", data, (k << 5) | 1);
            tick(1);
        end
        ready = 0;
        chk("lit_ovf_empty", valid, 0);
        chk("lit_ovf_sticky", ovf, 1);

        // clr collides with event and pop while 3 records held
        en = 1; evt = 5'b00001;
        tick(3);
        chk("lit_clr_pre_level", level, 3);
        clr = 1; ready = 1;
        tick(1);
        clr = 0; en = 0; evt = 0; ready = 0; sel = 0;
        chk("lit_clr_level", level, 0);
        chk("lit_clr_valid", valid, 0);
        chk("lit_clr_ovf", ovf, 0);
        tick(2);
        chk("lit_clr_cnt", cnt_o, 0);

        // Full FIFO with simultaneous push and pop
        clr = 1; tick(1); clr = 0;
        en = 1; evt = 5'b00001;
        tick(8);
        en = 0; evt = 0;
        chk("lit_full_level", level, 8);
        en = 1; evt = 5'b00001; ready = 1;
        tick(1);
        en = 0; evt = 0; ready = 0;
        chk("lit_fullpop_level", level, 8);
        chk("lit_fullpop_ovf", ovf, 0);
        chk("lit_fullpop_head", data, 21'h000021);

        // Asynchronous reset between edges
        clr = 1; tick(1); clr = 0;
        en = 1; evt = 5'b00001; sel = 0;
        tick(4);
        #3 reset = 1'b0;
        #1;
        chk("lit_arst_cnt", cnt_o, 0);
        chk("lit_arst_valid", valid, 0);
        chk("lit_arst_level", level, 0);
        chk("lit_arst_data", data, 0);
        chk("lit_arst_ovf", ovf, 0);
        @(negedge clk); #1 reset = 1'b1;
        tick(3);
        chk("lit_arst_resume", level, 3);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            en    = ($urandom % 10) != 0;
            evt   = 5'($urandom & $urandom);
            mask  = 5'($urandom);
            ready = ($urandom % 100) < ((i < 2000) ? 20 : 60);
            clr   = ($urandom % 64) == 0;
            sel   = 3'($urandom);
            if (($urandom % 500) == 0) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
                tick(1);
            end else begin
                tick(1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_event_monitor.md
# pipeline_event_monitor

Synthesizable successor to the bench-side flush/stall/branch event reporting for the pipelined RISC-V core. Sits beside `Top_Level`, takes one-cycle event strobes from the hazard unit and execute stage, and keeps per-event counters plus a cycle counter. Captures time-stamped event records in a trace FIFO drained over a valid/ready port. Event count, counter width, saturation mode, timestamp width and FIFO depth are parametrised.

## Interface
- `NUM_EVT`, 5: number of event inputs. Default order is StallF, StallD, FlushD, FlushE, PCSrcE.
- `CNT_W`, 32: width of every counter, cycle counter included.
- `SATURATE`, 1: 1 = counters stick at all-ones; 0 = counters wrap to 0.
- `TS_W`, 16: timestamp width in trace records, TS_W ≤ CNT_W.
- `DEPTH`, 8: trace FIFO entries. Must be a power of two, ≥ 2.
- `clk`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  count/capture enable.
- `clr`  in  1  synchronous clear of counters, FIFO and the overflow flag.
- `evt_i`  in  NUM_EVT  event strobes. Each bit is one event per cycle.
- `evt_mask_i`  in  NUM_EVT  per-event trace-capture enable. Counting ignores the mask.
- `sel_i`  in  $clog2(NUM_EVT+1)  counter select. Index NUM_EVT selects the cycle counter.
- `cnt_o`  out  CNT_W  registered value of the selected counter.
- `trace_valid_o`  out  1  FIFO non-empty.
- `trace_ready_i`  in  1  consumer accepts the head record.
- `trace_data_o`  out  TS_W+NUM_EVT  head record, laid out as {timestamp, masked event vector}.
- `trace_level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow_o`  out  1  sticky flag: a record was dropped.

## Operation
- **Cycle counter:** +1 on every cycle with `en`=1.
- **Event counter i:** +1 on every cycle with `en`=1 and `evt_i[i]`=1. All counters update in parallel.
- **Saturation:** with SATURATE=1, a counter at 2^CNT_W−1 holds. With SATURATE=0 it wraps to 0.
- **Capture condition:** `en`=1 and (`evt_i` & `evt_mask_i`) ≠ 0.
- **Record contents:** the record is {cycle counter[TS_W-1:0] before this cycle's increment, `evt_i` & `evt_mask_i`}. Multiple simultaneous events produce one record.
- **FIFO:** first-word-fall-through. `trace_data_o` is valid whenever `trace_valid_o`=1. A pop happens on `trace_valid_o` && `trace_ready_i`.
- **Full FIFO, capture, no pop:** the record is dropped and `overflow_o` is set. Counters still increment.
- **Full FIFO, capture and pop together:** the push is accepted and the level is unchanged.
- **Empty FIFO, capture, ready=1:** no bypass. The record appears the next cycle.
- **`clr` priority:** `clr` overrides everything. Same-cycle events are neither counted nor captured. A same-cycle pop is discarded.
- **`en`=0:** counters and captures freeze. Draining the FIFO still works.
- **Out-of-range select:** `sel_i` > NUM_EVT gives `cnt_o` = 0.

## Timing
- **Reset values:** all counters, `cnt_o`, FIFO pointers, `trace_level_o`, `overflow_o` and `trace_valid_o` are 0. `trace_data_o` is don't-care while invalid; the implementation drives 0.
- **Reset mid-operation:** reset is asynchronous and discards FIFO contents immediately.
- **Counter latency:** an event in cycle N is visible in `cnt_o` at N+2 (counter register, then output register).
- **`cnt_o` latency from select:** one cycle after a `sel_i` change.
- **Trace latency:** a capture in cycle N gives `trace_valid_o` at N+1.
- **Pop:** takes effect at the clock edge; the next head is presented in the following cycle.
- **`trace_level_o`:** registered; reflects pushes and pops from the previous edge.

## Structure
- **Package `perf_mon_pkg`:** event index constants `EVT_STALLF`=0, `EVT_STALLD`=1, `EVT_FLUSHD`=2, `EVT_FLUSHE`=3, `EVT_BRANCH`=4. Also holds a trace-record width function of TS_W and NUM_EVT.
- **Sub-module `trace_fifo`:** synchronous FWFT FIFO parametrised by WIDTH and DEPTH. It uses pointers one bit wider than the address for full/empty detection and reports `level`.
- **Counter array:** stays in the top module as a generate loop sharing one saturate/wrap increment function.

## Test plan
- **Basic counting:** reset, en=1, pulse `evt_i`=5'b00001 for 3 cycles, then sel_i=0. Expect `cnt_o`=3 and the cycle counter (sel_i=5) equal to the elapsed enabled cycles.
- **Saturate/wrap:** CNT_W=4, 20 cycles of `evt_i`[1]=1. SATURATE=1 gives `cnt_o`=15; SATURATE=0 gives `cnt_o`=4.
- **Trace capture and masking:** mask=5'b10100, `evt_i`=5'b10110 at cycle counter 7. Expect exactly one record {16'd7, 5'b10100}, valid the next cycle.
- **Overflow:** DEPTH=8, ready=0, 9 masked events. Expect level=8, `overflow_o`=1, and the first 8 records in order. Full-plus-pop in the same cycle is accepted with no overflow.
- **`clr` collision:** `clr`=1 with an event and ready=1 while 3 records are held. Expect level 0, counters 0, overflow 0, and the event not counted.
- **Async reset:** assert `reset`=0 mid-burst between edges. Expect all outputs 0 immediately and normal operation after release.
